// File: rtl/ppe_rr_scheduler_pkg.sv
// Shared constants, FSM state type and pointer helper for the round-robin
// grant scheduler and its pipelined programmable priority encoder.
package ppe_sched_pkg;

  localparam int N    = 512;
  localparam int IDXW = 9;
  localparam int LAT  = 3;
  localparam int WCW  = $clog2(LAT + 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    PRESENT
  } state_t;

  // N is a power of two, so the natural IDXW-bit wrap gives (idx+1) mod N.
  function automatic logic [IDXW-1:0] next_ptr(input logic [IDXW-1:0] idx);
    return idx + IDXW'(1);
  endfunction

endpackage

// File: rtl/ppe_rr_scheduler_if.sv
// Request/grant bus between the requester bank, the scheduler and the
// downstream consumer. The master side is the scheduler.
interface ppe_rr_scheduler_if;
  import ppe_sched_pkg::*;

  logic [N-1:0]    req;
  logic            gnt_valid;
  logic            gnt_ready;
  logic [IDXW-1:0] gnt_idx;

  modport master (
    input  req,
    input  gnt_ready,
    output gnt_valid,
    output gnt_idx
  );

  modport slave (
    output req,
    output gnt_ready,
    input  gnt_valid,
    input  gnt_idx
  );

endinterface

// File: rtl/ppe_rr_scheduler_core.sv
// Pipelined programmable priority encoder: finds the lowest set bit at or
// above ptr, wrapping to the lowest set bit overall, with latency LAT.
module ppe_core #(
  parameter int N    = 512,
  parameter int IDXW = 9,
  parameter int LAT  = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] ptr,
  output logic            out_valid,
  output logic [IDXW-1:0] idx,
  output logic            any
);

  logic [N-1:0]    mask;
  logic [N-1:0]    s1_masked;
  logic [N-1:0]    s1_raw;
  logic            s1_valid;
  logic [N-1:0]    oh_masked;
  logic [N-1:0]    oh_raw;
  logic [N-1:0]    oh_sel;
  logic [IDXW-1:0] enc;
  logic            any_c;

  function automatic logic [N-1:0] lowest_one(input logic [N-1:0] v);
    return v & (-v);
  endfunction

  // Thermometer mask: ones at every position at or above the pointer.
  always_comb begin
    mask = '0;
    for (int i = 0; i < N; i++) begin
      mask[i] = (i >= int'(ptr));
    end
  end

  // First stage captures the masked and raw request vectors; this register
  // is the scheduler's snapshot of the round.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_masked <= '0;
      s1_raw    <= '0;
    end else begin
      s1_valid  <= in_valid;
      s1_masked <= req & mask;
      s1_raw    <= req;
    end
  end

  // Masked search wins when it finds anything, otherwise wrap to the raw one.
  always_comb begin
    oh_masked = lowest_one(s1_masked);
    oh_raw    = lowest_one(s1_raw);
    oh_sel    = (|s1_masked) ? oh_masked : oh_raw;
    any_c     = |s1_raw;
    enc       = '0;
    for (int i = 0; i < N; i++) begin
      if (oh_sel[i]) begin
        enc = enc | IDXW'(i);
      end
    end
  end

  if (LAT > 1) begin : g_pipe
    logic [LAT-2:0]           p_valid;
    logic [LAT-2:0]           p_any;
    logic [LAT-2:0][IDXW-1:0] p_idx;

    // Delay the encoded result so the total latency comes to LAT.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        p_valid <= '0;
        p_any   <= '0;
        p_idx   <= '0;
      end else begin
        p_valid[0] <= s1_valid;
        p_any[0]   <= any_c;
        p_idx[0]   <= enc;
        for (int i = 1; i < LAT - 1; i++) begin
          p_valid[i] <= p_valid[i-1];
          p_any[i]   <= p_any[i-1];
          p_idx[i]   <= p_idx[i-1];
        end
      end
    end

    assign out_valid = p_valid[LAT-2];
    assign any       = p_any[LAT-2];
    assign idx       = p_idx[LAT-2];
  end else begin : g_direct
    assign out_valid = s1_valid;
    assign any       = any_c;
    assign idx       = enc;
  end

endmodule

// File: rtl/ppe_rr_scheduler.sv
// Round-robin grant scheduler: snapshots requests and pointer into the PPE,
// waits out its latency, presents one grant over valid/ready and advances
// the pointer past the winner.
module ppe_rr_scheduler
  import ppe_sched_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  ppe_rr_scheduler_if.master   bus,
  input  logic                 cfg_rr_en,
  input  logic                 cfg_ptr_ld,
  input  logic [IDXW-1:0]      cfg_ptr,
  output logic                 busy,
  output logic [IDXW-1:0]      ptr,
  output logic [31:0]          gnt_cnt
);

  state_t          state_q;
  state_t          state_d;
  logic [WCW-1:0]  wcnt_q;
  logic [WCW-1:0]  wcnt_d;
  logic            launch;
  logic            handshake;
  logic            grant_load;
  logic            core_valid;
  logic            core_any;
  logic [IDXW-1:0] core_idx;

  assign launch     = (state_q == IDLE) && (|bus.req);
  assign handshake  = (state_q == PRESENT) && bus.gnt_valid && bus.gnt_ready;
  assign grant_load = (state_q == WAIT) && (wcnt_q == WCW'(1)) && core_valid && core_any;
  assign busy       = (state_q != IDLE);

  ppe_core #(
    .N    (N),
    .IDXW (IDXW),
    .LAT  (LAT)
  ) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (launch),
    .req       (bus.req),
    .ptr       (ptr),
    .out_valid (core_valid),
    .idx       (core_idx),
    .any       (core_any)
  );

  // State and wait-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Next-state logic; a WAIT round without a PPE result falls back to IDLE
  // rather than presenting a stale index.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      IDLE: begin
        if (launch) begin
          state_d = WAIT;
          wcnt_d  = WCW'(LAT);
        end
      end
      WAIT: begin
        wcnt_d = wcnt_q - WCW'(1);
        if (wcnt_q == WCW'(1)) begin
          state_d = grant_load ? PRESENT : IDLE;
        end
      end
      PRESENT: begin
        if (handshake) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        wcnt_d  = '0;
      end
    endcase
  end

  // Grant output registers; the index is held after the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.gnt_valid <= 1'b0;
      bus.gnt_idx   <= '0;
    end else if (grant_load) begin
      bus.gnt_valid <= 1'b1;
      bus.gnt_idx   <= core_idx;
    end else if (handshake) begin
      bus.gnt_valid <= 1'b0;
    end
  end

  // Pointer: a software load takes precedence over the round-robin advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (cfg_ptr_ld) begin
      ptr <= cfg_ptr;
    end else if (handshake && cfg_rr_en) begin
      ptr <= next_ptr(bus.gnt_idx);
    end
  end

  // Saturating count of accepted grants.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_cnt <= '0;
    end else if (handshake && (gnt_cnt != 32'hFFFF_FFFF)) begin
      gnt_cnt <= gnt_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_ppe_rr_scheduler.sv
// Scoreboard bench for the round-robin grant scheduler: directed stimulus
// pushes hand-computed grant indices, a monitor pops them on each handshake.
module tb_ppe_rr_scheduler;
  import ppe_sched_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            cfg_rr_en;
  logic            cfg_ptr_ld;
  logic [IDXW-1:0] cfg_ptr;
  logic            busy;
  logic [IDXW-1:0] ptr;
  logic [31:0]     gnt_cnt;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int unsigned exp_q[$];

  ppe_rr_scheduler_if bus_if();

  ppe_rr_scheduler dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus_if.master),
    .cfg_rr_en  (cfg_rr_en),
    .cfg_ptr_ld (cfg_ptr_ld),
    .cfg_ptr    (cfg_ptr),
    .busy       (busy),
    .ptr        (ptr),
    .gnt_cnt    (gnt_cnt)
  );

  always #5 clk = ~clk;

  // Free-running cycle counter used to measure grant spacing.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_stimulus(input logic [N-1:0] r);
    bus_if.req = r;
  endtask

  function automatic logic [N-1:0] bits3(input int a, input int b, input int c);
    logic [N-1:0] v;
    v = '0;
    if (a >= 0) v[a] = 1'b1;
    if (b >= 0) v[b] = 1'b1;
    if (c >= 0) v[c] = 1'b1;
    return v;
  endfunction

  task automatic wait_valid(input string name, output int n);
    n = 0;
    do begin
      step(1);
      n++;
    end while (!bus_if.gnt_valid && n < 40);
    if (!bus_if.gnt_valid) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s: gnt_valid=0 after %0d cycles, required 1", name, n);
    end
  endtask

  // Scoreboard monitor plus the PPE-result / wait-counter alignment check.
  always @(negedge clk) begin
    if (rst_n && bus_if.gnt_valid && bus_if.gnt_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_grant: got %0d, required no grant", bus_if.gnt_idx);
      end else begin
        check_output("grant_idx", 32'(bus_if.gnt_idx), exp_q.pop_front());
      end
    end
    if (rst_n) begin
      checks++;
      assert (dut.core_valid == (dut.state_q == WAIT && dut.wcnt_q == 1)) else begin
        failures++;
        $display("[TB] FAIL ppe_align: out_valid=%0d, required %0d",
                 dut.core_valid, (dut.state_q == WAIT && dut.wcnt_q == 1));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    int t_prev;
    logic seen;
    int exp_grants[4];
    int exp_ptrs[4];

    rst_n      = 1'b0;
    cfg_rr_en  = 1'b1;
    cfg_ptr_ld = 1'b0;
    cfg_ptr    = '0;
    bus_if.gnt_ready = 1'b0;
    apply_stimulus('0);
    step(3);
    rst_n = 1'b1;

    // Idle after reset.
    step(20);
    check_output("rst_busy", 32'(busy), 0);
    check_output("rst_gnt_valid", 32'(bus_if.gnt_valid), 0);
    check_output("rst_gnt_idx", 32'(bus_if.gnt_idx), 0);
    check_output("rst_ptr", 32'(ptr), 0);
    check_output("rst_gnt_cnt", gnt_cnt, 0);

    // Round robin over {3,10,400}.
    exp_grants = '{3, 10, 400, 3};
    exp_ptrs   = '{4, 11, 401, 4};
    bus_if.gnt_ready = 1'b1;
    apply_stimulus(bits3(3, 10, 400));
    foreach (exp_grants[k]) exp_q.push_back(exp_grants[k]);
    t_prev = 0;
    for (int k = 0; k < 4; k++) begin
      wait_valid("rr_wait", n);
      if (k == 0) check_output("first_latency", n, LAT + 1);
      else        check_output("grant_spacing", cyc - t_prev, LAT + 2);
      t_prev = cyc;
      if (k == 3) apply_stimulus('0);
      step(1);
      check_output("rr_ptr", 32'(ptr), exp_ptrs[k]);
    end

    // Wrap-around from pointer 500.
    cfg_ptr_ld = 1'b1;
    cfg_ptr    = 9'd500;
    step(1);
    cfg_ptr_ld = 1'b0;
    check_output("ld_ptr_500", 32'(ptr), 500);
    apply_stimulus(bits3(5, 511, -1));
    exp_q.push_back(511);
    exp_q.push_back(5);
    wait_valid("wrap_wait1", n);
    step(1);
    check_output("wrap_ptr0", 32'(ptr), 0);
    wait_valid("wrap_wait2", n);
    apply_stimulus('0);
    step(1);
    check_output("wrap_ptr6", 32'(ptr), 6);

    // Backpressure holds the grant stable.
    bus_if.gnt_ready = 1'b0;
    apply_stimulus(bits3(20, -1, -1));
    exp_q.push_back(20);
    wait_valid("bp_wait", n);
    check_output("bp_cnt_before", gnt_cnt, 6);
    for (int k = 0; k < 10; k++) begin
      step(1);
      check_output("bp_valid_stable", 32'(bus_if.gnt_valid), 1);
      check_output("bp_idx_stable", 32'(bus_if.gnt_idx), 20);
    end
    check_output("bp_ptr_hold", 32'(ptr), 6);
    check_output("bp_cnt_hold", gnt_cnt, 6);
    bus_if.gnt_ready = 1'b1;
    apply_stimulus('0);
    step(1);
    check_output("bp_valid_drop", 32'(bus_if.gnt_valid), 0);
    check_output("bp_cnt_after", gnt_cnt, 7);
    check_output("bp_ptr_after", 32'(ptr), 21);
    step(5);
    check_output("bp_single_hs", gnt_cnt, 7);

    // Pointer load on the handshake edge beats the advance.
    bus_if.gnt_ready = 1'b0;
    apply_stimulus(bits3(50, -1, -1));
    exp_q.push_back(50);
    wait_valid("ldhs_wait", n);
    cfg_ptr_ld = 1'b1;
    cfg_ptr    = 9'd100;
    bus_if.gnt_ready = 1'b1;
    apply_stimulus('0);
    step(1);
    cfg_ptr_ld = 1'b0;
    check_output("ldhs_ptr", 32'(ptr), 100);
    check_output("ldhs_cnt", gnt_cnt, 8);

    // Pointer load during WAIT leaves the in-flight round alone.
    apply_stimulus(bits3(150, 60, -1));
    exp_q.push_back(150);
    step(1);
    check_output("ldwait_busy", 32'(busy), 1);
    cfg_ptr_ld = 1'b1;
    cfg_ptr    = 9'd0;
    step(1);
    cfg_ptr_ld = 1'b0;
    wait_valid("ldwait_wait", n);
    apply_stimulus('0);
    step(1);
    check_output("ldwait_ptr", 32'(ptr), 151);

    // Fixed priority: the pointer never moves.
    cfg_rr_en = 1'b0;
    apply_stimulus(bits3(3, 10, -1));
    repeat (3) exp_q.push_back(3);
    for (int k = 0; k < 3; k++) begin
      wait_valid("fixed_wait", n);
      if (k == 2) apply_stimulus('0);
    end
    step(1);
    check_output("fixed_ptr", 32'(ptr), 151);
    check_output("fixed_cnt", gnt_cnt, 12);
    cfg_rr_en = 1'b1;

    // Reset in the middle of WAIT aborts the round.
    apply_stimulus(bits3(300, -1, -1));
    step(2);
    rst_n = 1'b0;
    apply_stimulus('0);
    #1;
    check_output("mid_rst_busy", 32'(busy), 0);
    check_output("mid_rst_valid", 32'(bus_if.gnt_valid), 0);
    check_output("mid_rst_idx", 32'(bus_if.gnt_idx), 0);
    check_output("mid_rst_ptr", 32'(ptr), 0);
    check_output("mid_rst_cnt", gnt_cnt, 0);
    step(1);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step(1);
      seen = seen | bus_if.gnt_valid;
    end
    check_output("mid_rst_no_grant", 32'(seen), 0);
    apply_stimulus(bits3(7, -1, -1));
    exp_q.push_back(7);
    wait_valid("post_rst_wait", n);
    check_output("post_rst_latency", n, LAT + 1);
    apply_stimulus('0);
    step(1);
    check_output("post_rst_ptr", 32'(ptr), 8);

    step(5);
    check_output("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
